chunked_add_seq: RTL and testbench
==================================

// Module: chunked_add_seq
// PURPOSE
//   Multi-cycle sequencer that adds two WIDTH-bit operands by driving one CHUNK-bit
//   ripple adder slice (the 4-bit full-adder chain) once per cycle, LSB chunk first.
//   It registers the carry between chunks and returns sum, carry-out and signed overflow.
//   Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
//   WIDTH  16  operand/sum width; must be a multiple of CHUNK; min = CHUNK
//   CHUNK  4   bits added per cycle (slice width); NCHUNK = WIDTH/CHUNK
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/cin presented
//   in_ready   out  1      sequencer can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry into chunk 0
//   op_sub     in   1      subtract A-B (present only with CHUNKED_ADD_SUB_EN)
//   abort      in   1      synchronous cancel of any in-flight operation
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB chunk
//   ovf        out  1      signed overflow: carry into MSB xor carry out of MSB
//   busy       out  1      high in RUN
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0,
//     out_valid=0, busy=0. in_ready=1 is combinational from IDLE.
//   - FSM: IDLE -> RUN on in_valid&&in_ready. RUN -> DONE on the edge completing chunk
//     NCHUNK-1. DONE -> IDLE on out_valid&&out_ready. abort in any state -> IDLE next edge;
//     it clears out_valid/busy and does not change sum/cout/ovf.
//   - Accept edge: latch a, b, carry<=cin, idx<=0; state<=RUN.
//   - RUN cycle k: slice adds a[k*CHUNK+:CHUNK] + b[k*CHUNK+:CHUNK] + carry.
//     Sum chunk written to sum[k*CHUNK+:CHUNK]; carry<=slice carry-out; idx<=k+1.
//   - MSB chunk: capture the MSB-bit carry-in, then ovf<=cin_msb^cout_msb and cout<=carry-out.
//   - Latency: out_valid rises exactly NCHUNK edges after the accept edge (4 for the defaults).
//   - in_ready=1 only in IDLE: no overlap, and no accept in the same cycle as result handoff.
//   - DONE holds sum/cout/ovf/out_valid stable while out_ready=0 (unbounded backpressure).
//   - sum bits not yet computed in RUN are don't-care. Consumers sample only when out_valid=1.
//   - in_valid while busy is ignored, and operands are not re-sampled.
//   - abort and in_valid in the same IDLE cycle: abort wins, nothing is accepted.
//   - Reset mid-RUN or mid-DONE: immediate return to reset values; partial result is lost.
//   - idx wraps only via reset to 0 on accept; it never exceeds NCHUNK-1 in RUN.
// CONFIGURATION
//   CHUNKED_ADD_SUB_EN defined: op_sub port exists and is latched on accept.
//     op_sub=1: b is inverted chunk-wise and carry<=1, overriding cin. cout=1 means no borrow.
//   CHUNKED_ADD_SUB_EN undefined: op_sub port is absent; add only, and carry<=cin on accept.
// TESTING (WIDTH=16, CHUNK=4)
//   1. a=0xFFFF b=0x0001 cin=0 -> 4 cycles later out_valid=1, sum=0x0000 cout=1 ovf=0.
//   2. a=0x00F0 b=0x0010 cin=0 -> sum=0x0100 cout=0 (carry crosses chunk 1->2);
//      a=0x7FFF b=0x0001 -> sum=0x8000 ovf=1 cout=0.
//   3. Backpressure: result 0x1234+0x1111 with out_ready=0 for 5 cycles -> sum=0x2345 stable,
//      in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
//   4. rst_n=0 during RUN idx=2 -> outputs at reset values immediately; a new op after
//      release (0x0003+0x0004, cin=1) -> sum=0x0008.
//   5. abort at RUN idx=1 -> IDLE next edge, out_valid never rises; next op completes normally.
//   6. CHUNKED_ADD_SUB_EN: op_sub=1 a=0x0005 b=0x0007 -> sum=0xFFFE cout=0;
//      a=0x8000 b=0x0001 -> sum=0x7FFF ovf=1.

Source files
------------

// File: rtl/chunked_add_seq.sv
// chunked_add_seq: multi-cycle WIDTH-bit adder that drives one CHUNK-bit ripple
// slice per cycle, LSB chunk first, carrying between chunks in a register.
// valid/ready handshakes on the operand and result sides.
// Optional feature: define CHUNKED_ADD_SUB_EN to add the op_sub port (A-B mode).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding chunk idx this cycle, busy=1
// DONE  | result held, out_valid=1 until out_ready

module chunked_add_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADD_SUB_EN
    input  logic             op_sub,
`endif
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, slice_sum;
    logic [CHUNK:0]   slice_c;
    logic [WIDTH-1:0] b_eff;
    logic             carry_start;

    // Operand conditioning at accept: subtraction stores ~b and forces carry-in to 1.
    always_comb begin
        b_eff       = b;
        carry_start = cin;
`ifdef CHUNKED_ADD_SUB_EN
        if (op_sub) begin
            b_eff       = ~b;
            carry_start = 1'b1;
        end
`endif
    end

    // One CHUNK-bit ripple full-adder slice on the chunk selected by idx.
    always_comb begin
        a_chunk    = a_q[32'(idx_q) * CHUNK +: CHUNK];
        b_chunk    = b_q[32'(idx_q) * CHUNK +: CHUNK];
        slice_c    = '0;
        slice_sum  = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            slice_sum[i]   = a_chunk[i] ^ b_chunk[i] ^ slice_c[i];
            slice_c[i+1]   = (a_chunk[i] & b_chunk[i]) | (slice_c[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

    // Next-state and datapath update; abort has priority and leaves results untouched.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d = ST_RUN;
                        a_d     = a;
                        b_d     = b_eff;
                        carry_d = carry_start;
                        idx_d   = '0;
                    end
                end
                ST_RUN: begin
                    sum_d[32'(idx_q) * CHUNK +: CHUNK] = slice_sum;
                    carry_d = slice_c[CHUNK];
                    if (idx_q == LAST_IDX) begin
                        cout_d  = slice_c[CHUNK];
                        ovf_d   = slice_c[CHUNK-1] ^ slice_c[CHUNK];
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Testbench for chunked_add_seq (WIDTH=16, CHUNK=4): directed vector table,
// multi-cycle corner sequences, and randomized ops against an arithmetic model.
module tb_chunked_add_seq;

    localparam int NCHUNK = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op_sub;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chunked_add_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CHUNKED_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Whole-word arithmetic reference: returns {cout, ovf, sum}.
    function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic c, input logic s);
        logic [15:0] yy;
        logic        cc;
        logic [16:0] r;
        logic        v;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
        return {r[16], v, r[15:0]};
    endfunction

    // Accept one op, wait for result (bounded), check it, hold under backpressure, hand off.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input int hold,
                         input logic [15:0] es, input logic eco, input logic eov);
        int   n;
        logic stable;
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(NCHUNK));
        chk({tag, "_sum"},  32'(sum),  32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(eco));
        chk({tag, "_ovf"},  32'(ovf),  32'(eov));
        if (hold > 0) begin
            stable = 1'b1;
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                if (sum !== es || cout !== eco || ovf !== eov || out_valid !== 1'b1 || in_ready !== 1'b0)
                    stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [17:0] r;
        logic [15:0] ra, rb;
        logic        rc;
        logic        seen;
        int          n;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
        vecs[1] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 5};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
                  vecs[i].s, vecs[i].co, vecs[i].ov);

        // Reset while RUN at idx=2.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_sum",       32'(sum),       32'd0);
        chk("midrst_cout",      32'(cout),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op("after_rst", 16'h0003, 16'h0004, 1'b1, 0, 16'h0008, 1'b0, 1'b0);

        // Abort at RUN idx=1: output must never become valid.
        a = 16'h4321; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_busy",  32'(busy),     32'd0);
        chk("abort_run_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_run_no_valid", 32'(seen), 32'd0);
        do_op("after_abort", 16'h0102, 16'h0304, 1'b0, 0, 16'h0406, 1'b0, 1'b0);

        // abort and in_valid together in IDLE: nothing accepted.
        a = 16'h5555; b = 16'h5555; in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_idle_busy",  32'(busy),     32'd0);
        chk("abort_idle_ready", 32'(in_ready), 32'd1);

        // Abort in DONE: drops out_valid, keeps the result registers.
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("abort_done_latency", 32'(n), 32'(NCHUNK));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_valid", 32'(out_valid), 32'd0);
        chk("abort_done_ready", 32'(in_ready),  32'd1);
        chk("abort_done_sum",   32'(sum),       32'h1010);

`ifdef CHUNKED_ADD_SUB_EN
        op_sub = 1'b1;
        do_op("sub0", 16'h0005, 16'h0007, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub1", 16'h8000, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1);
        op_sub = 1'b0;
`endif

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i % 8 == 0) rb = 16'hFFFF - ra;
`ifdef CHUNKED_ADD_SUB_EN
            op_sub = 1'($urandom);
`endif
            r = ref_op(ra, rb, rc, op_sub);
            do_op($sformatf("rnd%0d", i), ra, rb, rc, int'($urandom_range(0, 3)),
                  r[15:0], r[17], r[16]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
